// File: rtl/vend_pkg.sv
// Coin codes and classifier state encoding shared by the sensor frontend and the vending FSM.
package vend_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE   = 2'b00;
  localparam coin_t COIN_NICKEL = 2'b01;
  localparam coin_t COIN_DIME   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NICKEL,
    ST_DIME,
    ST_BAD,
    ST_GAP
  } cls_state_e;

  localparam int unsigned REJECT_CNT_W = 8;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus debounce filter for one raw coin sensor.
// The filtered level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic sense_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, fall_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sense_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/coin_sensor_frontend.sv
// Debounces nickel/dime sensors, classifies coins and queues them for the vending FSM.
// Optional saturating reject counter enabled by defining COIN_REJECT_CNT_EN.
module coin_sensor_frontend
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES      = 8,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       nickel_sense,
  input  logic       dime_sense,
  input  logic       vend_busy,
  output logic [1:0] coin,
  output logic       coin_return,
  output logic       fifo_full
`ifdef COIN_REJECT_CNT_EN
  ,
  output logic [REJECT_CNT_W-1:0] reject_count
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  logic n_lvl, n_rise, n_fall;
  logic d_lvl, d_rise, d_fall;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel_db (
    .clock   (clock),
    .reset   (reset),
    .sense_i (nickel_sense),
    .level_o (n_lvl),
    .rise_o  (n_rise),
    .fall_o  (n_fall)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime_db (
    .clock   (clock),
    .reset   (reset),
    .sense_i (dime_sense),
    .level_o (d_lvl),
    .rise_o  (d_rise),
    .fall_o  (d_fall)
  );

  cls_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             push_req;
  coin_t            push_code;
  logic             fsm_reject;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (n_rise && d_rise)  state_d = ST_BAD;
        else if (n_rise)       state_d = d_lvl ? ST_BAD : ST_NICKEL;
        else if (d_rise)       state_d = n_lvl ? ST_BAD : ST_DIME;
      end
      ST_NICKEL: begin
        if (d_rise) begin
          state_d = ST_BAD;
        end else if (n_fall) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_DIME: begin
        if (n_rise) begin
          state_d = ST_BAD;
        end else if (d_fall) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_BAD: begin
        if (!n_lvl && !d_lvl) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        // A new coin arriving too early restarts the quiet window.
        if (n_rise || d_rise)                          gap_cnt_d = '0;
        else if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1))  state_d   = ST_IDLE;
        else                                           gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push_req   = 1'b0;
    push_code  = COIN_NONE;
    fsm_reject = 1'b0;
    case (state_q)
      ST_NICKEL: if (!d_rise && n_fall) begin
        push_req  = 1'b1;
        push_code = COIN_NICKEL;
      end
      ST_DIME: if (!n_rise && d_fall) begin
        push_req  = 1'b1;
        push_code = COIN_DIME;
      end
      ST_BAD:  fsm_reject = !n_lvl && !d_lvl;
      ST_GAP:  fsm_reject = n_rise || d_rise;
      default: ;
    endcase
  end

  coin_t            fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full_q, ret_q;
  logic             issue, at_cap, push_en, drop, reject;

  assign issue   = (occ_q != '0) && !vend_busy;
  assign at_cap  = (occ_q == OCC_W'(FIFO_DEPTH));
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_en = push_req && (!at_cap || issue);
  assign drop    = push_req && at_cap && !issue;
  assign reject  = fsm_reject || drop;
  assign occ_d   = occ_q + OCC_W'(push_en) - OCC_W'(issue);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      ret_q    <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue)   rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q  <= occ_d;
      full_q <= (occ_d == OCC_W'(FIFO_DEPTH));
      ret_q  <= reject;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) fifo_mem_q[wr_ptr_q] <= push_code;
  end

  assign coin        = issue ? fifo_mem_q[rd_ptr_q] : COIN_NONE;
  assign coin_return = ret_q;
  assign fifo_full   = full_q;

`ifdef COIN_REJECT_CNT_EN
  logic [REJECT_CNT_W-1:0] rej_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rej_cnt_q <= '0;
    end else if (reject && (rej_cnt_q != '1)) begin
      rej_cnt_q <= rej_cnt_q + 1'b1;
    end
  end

  assign reject_count = rej_cnt_q;
`endif

endmodule
